if_queue_fetcher: RTL and testbench

- Next-generation instruction fetch unit: issues one PC at a time to the icache.
- Tags each returned instruction with the predictor's jump decision and next PC.
- Buffers results in a parametrised FIFO so fetch is decoupled from dispatch stalls.
- Sits between icache/predictor and the dispatcher; the ROB drives rollback. Stale in-flight icache responses after rollback are dropped, never dispatched.

---
 rtl/if_queue_fetcher.sv | 110 +++++++++++
 tb/tb_if_queue_fetcher.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_queue_fetcher.sv
// Instruction fetch unit: issues one PC at a time to the icache, tags each
// response with the predictor's decision and buffers it in a small FIFO.
module if_queue_fetcher #(
  parameter int DATA_W      = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int QPTR_W      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  output logic                rdy_to_fetch,
  output logic [DATA_W-1:0]   pc_2icache,
  input  logic                instr_valid,
  input  logic [DATA_W-1:0]   instr_from_icache,
  output logic                valid_2pred,
  output logic [DATA_W-1:0]   instr_2pred,
  output logic [DATA_W-1:0]   cur_pc,
  input  logic                if_jump,
  input  logic [DATA_W-1:0]   next_pc,
  input  logic                dsp_ready,
  output logic                valid_2dsp,
  output logic                if_jump_2dsp,
  output logic [DATA_W-1:0]   pc_2dsp,
  output logic [DATA_W-1:0]   instr_2dsp,
  output logic [QPTR_W:0]     queue_count,
  input  logic                rollback_signal,
  input  logic [DATA_W-1:0]   rollback_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  localparam logic [QPTR_W:0] FULL_CNT = (QPTR_W+1)'(QUEUE_DEPTH);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   pc;
  logic [QPTR_W-1:0]   head, tail;
  logic                push, pop, issue, active;

  logic [DATA_W-1:0]   mem_pc    [QUEUE_DEPTH];
  logic [DATA_W-1:0]   mem_instr [QUEUE_DEPTH];
  logic                mem_jump  [QUEUE_DEPTH];

  always_comb begin
    active = rdy && !rollback_signal;
    push   = active && (state == FETCH) && instr_valid;
    pop    = active && (queue_count != '0) && dsp_ready;
    issue  = active && (state == IDLE) && (queue_count < FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  // A rollback with a request in flight parks in DROP so the stale response is swallowed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rollback_signal && queue_count < FULL_CNT) state_nxt = FETCH;
      FETCH:   if (instr_valid) state_nxt = IDLE;
               else if (rollback_signal) state_nxt = DROP;
      DROP:    if (instr_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy_to_fetch = (state != IDLE);
    valid_2pred  = instr_valid && (state == FETCH) && !rollback_signal;
    instr_2pred  = instr_from_icache;
    cur_pc       = pc;
    valid_2dsp   = (queue_count != '0);
    if_jump_2dsp = valid_2dsp ? mem_jump[head]  : 1'b0;
    pc_2dsp      = valid_2dsp ? mem_pc[head]    : '0;
    instr_2dsp   = valid_2dsp ? mem_instr[head] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      pc_2icache  <= '0;
      head        <= '0;
      tail        <= '0;
      queue_count <= '0;
    end else if (rdy) begin
      if (rollback_signal) begin
        pc          <= rollback_pc;
        head        <= '0;
        tail        <= '0;
        queue_count <= '0;
      end else begin
        if (issue) pc_2icache <= pc;
        if (push)  pc <= next_pc;
        if (push)  tail <= tail + 1'b1;
        if (pop)   head <= head + 1'b1;
        if (push && !pop)      queue_count <= queue_count + 1'b1;
        else if (pop && !push) queue_count <= queue_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]    <= pc;
      mem_instr[tail] <= instr_from_icache;
      mem_jump[tail]  <= if_jump;
    end
  end

endmodule

// File: tb/tb_if_queue_fetcher.sv
// Directed self-checking bench for if_queue_fetcher.
module tb_if_queue_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        rdy_to_fetch;
  logic [31:0] pc_2icache;
  logic        instr_valid;
  logic [31:0] instr_from_icache;
  logic        valid_2pred;
  logic [31:0] instr_2pred, cur_pc;
  logic        if_jump;
  logic [31:0] next_pc;
  logic        dsp_ready;
  logic        valid_2dsp, if_jump_2dsp;
  logic [31:0] pc_2dsp, instr_2dsp;
  logic [2:0]  queue_count;
  logic        rollback_signal;
  logic [31:0] rollback_pc;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  if_queue_fetcher #(.DATA_W(32), .QUEUE_DEPTH(4), .QPTR_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rdy_to_fetch(rdy_to_fetch), .pc_2icache(pc_2icache),
    .instr_valid(instr_valid), .instr_from_icache(instr_from_icache),
    .valid_2pred(valid_2pred), .instr_2pred(instr_2pred), .cur_pc(cur_pc),
    .if_jump(if_jump), .next_pc(next_pc),
    .dsp_ready(dsp_ready), .valid_2dsp(valid_2dsp), .if_jump_2dsp(if_jump_2dsp),
    .pc_2dsp(pc_2dsp), .instr_2dsp(instr_2dsp), .queue_count(queue_count),
    .rollback_signal(rollback_signal), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a request, check its PC, then return one response.
  task automatic serve(input logic [31:0] exp_pc, input logic [31:0] instr,
                       input logic jmp, input logic [31:0] npc);
    int unsigned t = 0;
    while (rdy_to_fetch !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check_eq("req_valid", 32'(rdy_to_fetch), 32'd1);
    check_eq("req_pc", pc_2icache, exp_pc);
    instr_valid = 1'b1; instr_from_icache = instr; if_jump = jmp; next_pc = npc;
    tick();
    instr_valid = 1'b0; if_jump = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; instr_valid = 1'b0; instr_from_icache = '0;
    if_jump = 1'b0; next_pc = '0; dsp_ready = 1'b0;
    rollback_signal = 1'b0; rollback_pc = '0;

    // Reset values and first fetch.
    tick(); tick();
    check_eq("rst_rdy_to_fetch", 32'(rdy_to_fetch), 32'd0);
    check_eq("rst_pc_2icache", pc_2icache, 32'd0);
    check_eq("rst_valid_2dsp", 32'(valid_2dsp), 32'd0);
    check_eq("rst_count", 32'(queue_count), 32'd0);
    check_eq("rst_pc_2dsp", pc_2dsp, 32'd0);
    rst = 1'b0; dsp_ready = 1'b1;
    tick();
    check_eq("t1_req", 32'(rdy_to_fetch), 32'd1);
    check_eq("t1_req_pc", pc_2icache, 32'd0);
    tick(); tick();
    instr_valid = 1'b1; instr_from_icache = 32'h13; next_pc = 32'd4;
    #1;
    check_eq("t1_valid_2pred", 32'(valid_2pred), 32'd1);
    check_eq("t1_instr_2pred", instr_2pred, 32'h13);
    check_eq("t1_cur_pc", cur_pc, 32'd0);
    tick();
    instr_valid = 1'b0;
    check_eq("t1_valid_2dsp", 32'(valid_2dsp), 32'd1);
    check_eq("t1_pc_2dsp", pc_2dsp, 32'd0);
    check_eq("t1_instr_2dsp", instr_2dsp, 32'h13);
    check_eq("t1_jump_2dsp", 32'(if_jump_2dsp), 32'd0);
    check_eq("t1_req_idle", 32'(rdy_to_fetch), 32'd0);
    tick();
    check_eq("t1_popped", 32'(valid_2dsp), 32'd0);
    check_eq("t1_next_req", 32'(rdy_to_fetch), 32'd1);
    check_eq("t1_next_pc", pc_2icache, 32'd4);

    // Fill the queue, then drain in order.
    dsp_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++)
      serve(32'(i * 4), 32'hA0 + 32'(i), 1'b0, 32'((i + 1) * 4));
    check_eq("t2_full_count", 32'(queue_count), 32'd4);
    tick(); tick();
    check_eq("t2_no_issue", 32'(rdy_to_fetch), 32'd0);
    dsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_pop_valid", 32'(valid_2dsp), 32'd1);
      check_eq("t2_pop_pc", pc_2dsp, 32'(i * 4));
      check_eq("t2_pop_instr", instr_2dsp, 32'hA0 + 32'(i));
      tick();
    end
    check_eq("t2_empty", 32'(valid_2dsp), 32'd0);
    serve(32'd16, 32'hA4, 1'b0, 32'd20);

    // Predicted-taken branch redirects fetch.
    do_reset();
    serve(32'd0, 32'hB0, 1'b0, 32'd4);
    serve(32'd4, 32'hB1, 1'b0, 32'd8);
    serve(32'd8, 32'hB2, 1'b1, 32'h100);
    check_eq("t3_jump_flag", 32'(if_jump_2dsp), 32'd1);
    check_eq("t3_jump_pc", pc_2dsp, 32'd8);
    serve(32'h100, 32'hB3, 1'b0, 32'h104);

    // Rollback with a request outstanding and two entries queued.
    dsp_ready = 1'b0;
    do_reset();
    serve(32'd0, 32'hC0, 1'b0, 32'd4);
    serve(32'd4, 32'hC1, 1'b0, 32'h10);
    tick();
    check_eq("t4_count2", 32'(queue_count), 32'd2);
    check_eq("t4_req_pc", pc_2icache, 32'h10);
    rollback_signal = 1'b1; rollback_pc = 32'h200;
    tick();
    rollback_signal = 1'b0;
    check_eq("t4_flushed", 32'(queue_count), 32'd0);
    check_eq("t4_flush_valid", 32'(valid_2dsp), 32'd0);
    check_eq("t4_still_req", 32'(rdy_to_fetch), 32'd1);
    check_eq("t4_req_stable", pc_2icache, 32'h10);
    check_eq("t4_cur_pc", cur_pc, 32'h200);
    tick();
    instr_valid = 1'b1; instr_from_icache = 32'hDEAD; next_pc = 32'h14;
    #1;
    check_eq("t4_stale_pred", 32'(valid_2pred), 32'd0);
    tick();
    instr_valid = 1'b0;
    check_eq("t4_stale_dropped", 32'(valid_2dsp), 32'd0);
    check_eq("t4_drop_idle", 32'(rdy_to_fetch), 32'd0);
    serve(32'h200, 32'hC2, 1'b0, 32'h204);

    // Rollback coincident with response and dispatch.
    do_reset();
    dsp_ready = 1'b0;
    serve(32'd0, 32'hD0, 1'b0, 32'd4);
    serve(32'd4, 32'hD1, 1'b0, 32'd8);
    tick();
    dsp_ready = 1'b1; instr_valid = 1'b1; instr_from_icache = 32'hD2; next_pc = 32'h999;
    rollback_signal = 1'b1; rollback_pc = 32'h200;
    #1;
    check_eq("t5_no_pred", 32'(valid_2pred), 32'd0);
    tick();
    instr_valid = 1'b0; rollback_signal = 1'b0;
    check_eq("t5_count", 32'(queue_count), 32'd0);
    check_eq("t5_idle", 32'(rdy_to_fetch), 32'd0);
    check_eq("t5_cur_pc", cur_pc, 32'h200);
    tick();
    check_eq("t5_req", 32'(rdy_to_fetch), 32'd1);
    check_eq("t5_req_pc", pc_2icache, 32'h200);

    // rdy low freezes a pending fetch; then reset with three entries queued.
    dsp_ready = 1'b0;
    do_reset();
    serve(32'd0, 32'hE0, 1'b0, 32'd4);
    tick();
    rdy = 1'b0; instr_valid = 1'b1; instr_from_icache = 32'hE1; next_pc = 32'd8;
    tick();
    instr_valid = 1'b0;
    tick();
    check_eq("t6_frozen_req", 32'(rdy_to_fetch), 32'd1);
    check_eq("t6_frozen_pc", pc_2icache, 32'd4);
    check_eq("t6_frozen_count", 32'(queue_count), 32'd1);
    check_eq("t6_frozen_cur", cur_pc, 32'd4);
    rdy = 1'b1;
    serve(32'd4, 32'hE1, 1'b0, 32'd8);
    serve(32'd8, 32'hE2, 1'b0, 32'd12);
    check_eq("t6_count3", 32'(queue_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_rst_req", 32'(rdy_to_fetch), 32'd0);
    check_eq("t6_rst_pc", pc_2icache, 32'd0);
    check_eq("t6_rst_valid", 32'(valid_2dsp), 32'd0);
    check_eq("t6_rst_count", 32'(queue_count), 32'd0);
    check_eq("t6_rst_pc_2dsp", pc_2dsp, 32'd0);
    check_eq("t6_rst_instr_2dsp", instr_2dsp, 32'd0);
    check_eq("t6_rst_jump_2dsp", 32'(if_jump_2dsp), 32'd0);
    check_eq("t6_rst_cur_pc", cur_pc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
